// File: rtl/adc_lvds_tx_frame_gen_if.sv
// Input word stream into the LVDS frame transmitter: one word per lane,
// packed with lane i at [i*WORD_W +: WORD_W], moved on s_valid & s_ready.
interface adc_lvds_tx_frame_gen_if #(
    parameter int WORD_W = 16,
    parameter int LANES  = 2
);
    logic                      s_valid;
    logic                      s_ready;
    logic [LANES*WORD_W-1:0]   s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/adc_lvds_tx_frame_gen.sv
// ADC LVDS frame transmitter: takes parallel words from a one-entry holding
// buffer and serializes them MSB-first on LANES data lines while generating
// the FCO frame clock. Frames can be slipped (one bit short) or stretched
// (one bit long) on request, and a fixed test pattern can replace the data.
// FCO_HIGH must lie in 1..WORD_W-2 so FCO toggles even in a slipped frame.
module adc_lvds_tx_frame_gen #(
    parameter int                WORD_W    = 16,
    parameter int                LANES     = 2,
    parameter int                FCO_HIGH  = 8,
    parameter logic [WORD_W-1:0] IDLE_WORD = '0,
    parameter int                ERR_W     = 16
) (
    input  logic                  dco_clk,
    input  logic                  rst_n,
    input  logic                  enable,
    adc_lvds_tx_frame_gen_if.slave s_if,
    input  logic                  test_pattern_en,
    input  logic [WORD_W-1:0]     test_pattern,
    input  logic                  slip_req,
    input  logic                  stretch_req,
    output logic                  fco_out,
    output logic [LANES-1:0]      dout,
    output logic                  bit_valid,
    output logic                  frame_start,
    output logic                  underrun_pulse,
    output logic [ERR_W-1:0]      underrun_count
);

    localparam int CNT_W = $clog2(WORD_W + 2);
    localparam logic [CNT_W-1:0] LEN_NOM     = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] LEN_SLIP    = CNT_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0] LEN_STRETCH = CNT_W'(WORD_W + 1);
    localparam logic [CNT_W-1:0] FCO_HIGH_C  = CNT_W'(FCO_HIGH);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    typedef logic [LANES-1:0][WORD_W-1:0] lane_words_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       len_q, len_d;
    lane_words_t            shift_q, shift_d;
    lane_words_t            hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic                   slip_pend_q, slip_pend_d;
    logic                   stretch_pend_q, stretch_pend_d;
    logic                   ready_en_q;
    logic                   fco_q, fco_d;
    logic [LANES-1:0]       dout_q, dout_d;
    logic                   bit_valid_q, bit_valid_d;
    logic                   frame_start_q, frame_start_d;
    logic                   underrun_pulse_q, underrun_pulse_d;
    logic [ERR_W-1:0]       underrun_cnt_q, underrun_cnt_d;

    lane_words_t            frame_word;
    logic [CNT_W-1:0]       bit_cnt_inc;
    logic                   last_bit;
    logic                   start_frame;
    logic                   accept;

    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);
    assign last_bit    = (bit_cnt_q == (len_q - CNT_W'(1)));
    // A new frame begins on the edge that leaves the last bit (or IDLE) with
    // enable high; that same edge frees the holding buffer for the next word.
    assign start_frame = enable && ((state_q == ST_IDLE) || last_bit);
    assign s_if.s_ready = ready_en_q && (!hold_full_q || start_frame);
    assign accept      = s_if.s_valid && s_if.s_ready;

    assign fco_out        = fco_q;
    assign dout           = dout_q;
    assign bit_valid      = bit_valid_q;
    assign frame_start    = frame_start_q;
    assign underrun_pulse = underrun_pulse_q;
    assign underrun_count = underrun_cnt_q;

    // Sequencing, framing, buffer handoff and the registered values of every output bit.
    always_comb begin
        state_d          = state_q;
        bit_cnt_d        = bit_cnt_q;
        len_d            = len_q;
        shift_d          = shift_q;
        hold_d           = hold_q;
        hold_full_d      = hold_full_q;
        slip_pend_d      = slip_pend_q | slip_req;
        stretch_pend_d   = stretch_pend_q | stretch_req;
        underrun_cnt_d   = underrun_cnt_q;
        fco_d            = 1'b0;
        dout_d           = '0;
        bit_valid_d      = 1'b0;
        frame_start_d    = 1'b0;
        underrun_pulse_d = 1'b0;
        frame_word       = '0;

        if (accept) begin
            hold_d      = lane_words_t'(s_if.s_data);
            hold_full_d = 1'b1;
        end

        if (start_frame) begin
            state_d        = ST_RUN;
            bit_cnt_d      = '0;
            slip_pend_d    = slip_req;
            stretch_pend_d = stretch_req;
            if (slip_pend_q && !stretch_pend_q) begin
                len_d = LEN_SLIP;
            end else if (stretch_pend_q && !slip_pend_q) begin
                len_d = LEN_STRETCH;
            end else begin
                len_d = LEN_NOM;
            end

            hold_full_d = accept;
            if (test_pattern_en) begin
                frame_word = {LANES{test_pattern}};
            end else if (hold_full_q) begin
                frame_word = hold_q;
            end else begin
                frame_word       = {LANES{IDLE_WORD}};
                underrun_pulse_d = 1'b1;
                if (!(&underrun_cnt_q)) begin
                    underrun_cnt_d = underrun_cnt_q + ERR_W'(1);
                end
            end

            for (int i = 0; i < LANES; i++) begin
                dout_d[i]  = frame_word[i][WORD_W-1];
                shift_d[i] = {frame_word[i][WORD_W-2:0], 1'b0};
            end
            fco_d         = 1'b1;
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (last_bit) begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_inc;
                for (int i = 0; i < LANES; i++) begin
                    dout_d[i]  = shift_q[i][WORD_W-1];
                    shift_d[i] = {shift_q[i][WORD_W-2:0], 1'b0};
                end
                fco_d       = (bit_cnt_inc < FCO_HIGH_C);
                bit_valid_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any frame in progress at once.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            bit_cnt_q        <= '0;
            len_q            <= '0;
            shift_q          <= '0;
            hold_q           <= '0;
            hold_full_q      <= 1'b0;
            slip_pend_q      <= 1'b0;
            stretch_pend_q   <= 1'b0;
            ready_en_q       <= 1'b0;
            fco_q            <= 1'b0;
            dout_q           <= '0;
            bit_valid_q      <= 1'b0;
            frame_start_q    <= 1'b0;
            underrun_pulse_q <= 1'b0;
            underrun_cnt_q   <= '0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            len_q            <= len_d;
            shift_q          <= shift_d;
            hold_q           <= hold_d;
            hold_full_q      <= hold_full_d;
            slip_pend_q      <= slip_pend_d;
            stretch_pend_q   <= stretch_pend_d;
            ready_en_q       <= 1'b1;
            fco_q            <= fco_d;
            dout_q           <= dout_d;
            bit_valid_q      <= bit_valid_d;
            frame_start_q    <= frame_start_d;
            underrun_pulse_q <= underrun_pulse_d;
            underrun_cnt_q   <= underrun_cnt_d;
        end
    end

endmodule

// File: tb/tb_adc_lvds_tx_frame_gen.sv
// Bench for the LVDS frame transmitter. Every word handed to the source also
// queues its expected serial frame, bit by bit; a monitor pops one expected
// bit per bit_valid cycle and compares FCO, frame_start, underrun and data.
module tb_adc_lvds_tx_frame_gen;

    localparam int WORD_W   = 16;
    localparam int LANES    = 2;
    localparam int FCO_HIGH = 8;
    localparam int ERR_W    = 16;

    typedef struct packed {
        logic             fco;
        logic             fs;
        logic             ur;
        logic [LANES-1:0] dout;
    } bit_exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              tp_en;
    logic [WORD_W-1:0] tp;
    logic              slip_req;
    logic              stretch_req;
    logic              fco_out;
    logic [LANES-1:0]  dout;
    logic              bit_valid;
    logic              frame_start;
    logic              underrun_pulse;
    logic [ERR_W-1:0]  underrun_count;

    bit_exp_t                 exp_q[$];
    logic [LANES*WORD_W-1:0]  src_q[$];
    int checks = 0;
    int errors = 0;

    adc_lvds_tx_frame_gen_if #(.WORD_W(WORD_W), .LANES(LANES)) s_if ();

    adc_lvds_tx_frame_gen #(
        .WORD_W   (WORD_W),
        .LANES    (LANES),
        .FCO_HIGH (FCO_HIGH),
        .IDLE_WORD(16'h0000),
        .ERR_W    (ERR_W)
    ) dut (
        .dco_clk        (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .s_if           (s_if.slave),
        .test_pattern_en(tp_en),
        .test_pattern   (tp),
        .slip_req       (slip_req),
        .stretch_req    (stretch_req),
        .fco_out        (fco_out),
        .dout           (dout),
        .bit_valid      (bit_valid),
        .frame_start    (frame_start),
        .underrun_pulse (underrun_pulse),
        .underrun_count (underrun_count)
    );

    // 10 ns bit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected serial image of one frame: MSB first, extra stretch bit is 0.
    task automatic push_frame(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1,
                              input int len, input logic ur);
        bit_exp_t e;
        for (int k = 0; k < len; k++) begin
            e.fco  = (k < FCO_HIGH);
            e.fs   = (k == 0);
            e.ur   = ur && (k == 0);
            e.dout = '0;
            if (k < WORD_W) begin
                e.dout[0] = w0[WORD_W-1-k];
                e.dout[1] = w1[WORD_W-1-k];
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
        src_q.push_back({w1, w0});
    endtask

    task automatic applyStimulus(input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1, input int len);
        push_word(w0, w1);
        push_frame(w0, w1, len, 1'b0);
    endtask

    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_start && n < 100);
        if (!frame_start) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_start_timeout: got no frame_start within %0d cycles expected one", n);
        end
    endtask

    // Stream source: presents the queue head and drops it once the DUT takes it.
    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = '0;
        forever begin
            @(negedge clk);
            #1;
            if (src_q.size() > 0) begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = src_q[0];
            end else begin
                s_if.s_valid = 1'b0;
                s_if.s_data  = '0;
            end
            #2;
            if (s_if.s_valid && s_if.s_ready && src_q.size() > 0) begin
                void'(src_q.pop_front());
            end
        end
    end

    // Monitor: every driven bit must match the next expected bit.
    always @(negedge clk) begin
        bit_exp_t e;
        if (rst_n === 1'b1 && bit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_bit: got bit_valid=1 expected no pending frame bits");
            end else begin
                e = exp_q.pop_front();
                checkOutput("bit_stream{fco,fs,ur,dout}",
                            32'({fco_out, frame_start, underrun_pulse, dout}), 32'(e));
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_ur;
        int n;
        rst_n       = 1'b0;
        enable      = 1'b0;
        tp_en       = 1'b0;
        tp          = 16'h3C96;
        slip_req    = 1'b0;
        stretch_req = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_fco", 32'(fco_out), 0);
        checkOutput("rst_dout", 32'(dout), 0);
        checkOutput("rst_bit_valid", 32'(bit_valid), 0);
        checkOutput("rst_frame_start", 32'(frame_start), 0);
        checkOutput("rst_underrun_pulse", 32'(underrun_pulse), 0);
        checkOutput("rst_underrun_count", 32'(underrun_count), 0);
        checkOutput("rst_s_ready", 32'(s_if.s_ready), 0);

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(s_if.s_ready), 1);

        // Frames 1..9: nominal, slip, nominal, cancelled pair, stretch, nominal.
        repeat (4) applyStimulus(16'hA5C3, 16'h0FF0, 16);
        applyStimulus(16'h8001, 16'h1234, 15);
        applyStimulus(16'h5A5A, 16'hCAFE, 16);
        applyStimulus(16'hF00F, 16'h0F0F, 16);
        applyStimulus(16'hFFFF, 16'h0001, 17);
        applyStimulus(16'h1357, 16'h2468, 16);
        // Frames 10..12 starve and send the idle word.
        repeat (3) push_frame(16'h0000, 16'h0000, 16, 1'b1);

        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_frame_start();
        repeat (3) wait_frame_start();
        repeat (4) @(negedge clk);
        slip_req = 1'b1;
        @(negedge clk);
        slip_req = 1'b0;
        wait_frame_start();
        wait_frame_start();
        repeat (3) @(negedge clk);
        slip_req    = 1'b1;
        stretch_req = 1'b1;
        @(negedge clk);
        slip_req    = 1'b0;
        stretch_req = 1'b0;
        wait_frame_start();
        repeat (2) @(negedge clk);
        stretch_req = 1'b1;
        @(negedge clk);
        stretch_req = 1'b0;

        n_ur = 0;
        n    = 0;
        while (n_ur < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (underrun_pulse) n_ur++;
        end
        checkOutput("underrun_pulses_seen", 32'(n_ur), 3);
        checkOutput("underrun_count_3", 32'(underrun_count), 3);

        // Frame 13 real data, frames 14/15 test pattern (first consumes a word, second has none).
        applyStimulus(16'hBEEF, 16'h7E57, 16);
        push_word(16'hDEAD, 16'hD00D);
        push_frame(16'h3C96, 16'h3C96, 16, 1'b0);
        push_frame(16'h3C96, 16'h3C96, 16, 1'b0);
        wait_frame_start();
        repeat (15) @(negedge clk);
        tp_en = 1'b1;
        wait_frame_start();
        wait_frame_start();
        tp_en = 1'b0;
        applyStimulus(16'h0123, 16'hFEDC, 16);
        checkOutput("no_underrun_in_test_pattern", 32'(underrun_count), 3);

        // Frame 16: drop enable at bit 5; frame still runs to bit 15.
        wait_frame_start();
        repeat (5) @(negedge clk);
        enable = 1'b0;
        applyStimulus(16'hC3A5, 16'h5AA5, 16);
        repeat (10) @(negedge clk);
        checkOutput("last_bit_still_valid", 32'(bit_valid), 1);
        @(negedge clk);
        checkOutput("idle_bit_valid", 32'(bit_valid), 0);
        checkOutput("idle_fco", 32'(fco_out), 0);
        checkOutput("idle_dout", 32'(dout), 0);
        push_word(16'h4242, 16'h2424);
        repeat (3) @(negedge clk);
        checkOutput("idle_full_not_ready", 32'(s_if.s_ready), 0);
        enable = 1'b1;
        @(negedge clk);
        checkOutput("reenable_frame_start", 32'(frame_start), 1);
        checkOutput("reenable_bit_valid", 32'(bit_valid), 1);

        // Reset at bit 9 of frame 17 aborts it.
        repeat (9) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        src_q.delete();
        checkOutput("midreset_fco", 32'(fco_out), 0);
        checkOutput("midreset_dout", 32'(dout), 0);
        checkOutput("midreset_bit_valid", 32'(bit_valid), 0);
        checkOutput("midreset_underrun_count", 32'(underrun_count), 0);

        // After release with enable high: starved fresh frame, then real data.
        push_frame(16'h0000, 16'h0000, 16, 1'b1);
        applyStimulus(16'h9999, 16'h6666, 16);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_frame_start();
        checkOutput("post_reset_underrun_count", 32'(underrun_count), 1);
        wait_frame_start();
        enable = 1'b0;
        n = 0;
        while (bit_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("final_idle", 32'(bit_valid), 0);
        checkOutput("expected_bits_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_lvds_tx_frame_gen.md
Name: adc_lvds_tx_frame_gen

Overview:
- Synthesizable frame transmitter/serializer: the sending end of the ADC LVDS DCO/FCO/data interface that the frontend receives.
- Accepts parallel sample words over a valid/ready stream and serializes them MSB-first, one bit per lane per dco_clk.
- Generates the FCO frame clock.
- Supports fault injection (frame slip/stretch) and a fixed test-pattern mode.
- Used as the stimulus source for the receive path and its alignment monitor in loopback and emulation builds.

Parameters:
- WORD_W, 16: bits per frame per lane; nominal frame length in dco_clk cycles.
- LANES, 2: number of serial data lanes.
- FCO_HIGH, 8: FCO high-phase length in bits; must satisfy 1 <= FCO_HIGH <= WORD_W-2.
- IDLE_WORD, 16'h0000: per-lane word sent on underrun.
- ERR_W, 16: underrun counter width.

Ports:
- dco_clk  in  1  bit clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  run request.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- s_data  in  LANES*WORD_W  lane i word at [i*WORD_W +: WORD_W].
- test_pattern_en  in  1  replace data with test_pattern on all lanes.
- test_pattern  in  WORD_W  fixed pattern word.
- slip_req  in  1  pulse: next frame is WORD_W-1 bits.
- stretch_req  in  1  pulse: next frame is WORD_W+1 bits.
- fco_out  out  1  frame clock.
- dout  out  LANES  serial data, one bit per lane.
- bit_valid  out  1  high on every cycle a bit is driven (receiver word_valid).
- frame_start  out  1  pulse coincident with bit 0 of each frame.
- underrun_pulse  out  1  pulse: frame started with no word held.
- underrun_count  out  ERR_W  saturating underrun count.

Behaviour:
- Reset values: all outputs 0. s_ready=1 once out of reset. Holding buffer empty, pending requests cleared, state IDLE.
- Reset asserted mid-frame aborts the frame immediately; no partial completion.
- State machine:
  - IDLE -> RUN on the first cycle with enable=1; that cycle is bit 0 of frame 1.
  - RUN -> IDLE at the end of a frame (after the last bit) if enable=0 at that point. Deasserting enable mid-frame always completes the current frame.
  - In IDLE: fco_out=0, dout=0, bit_valid=0, frame_start=0.
- Frame timing:
  - Bit counter runs 0..len-1.
  - len is latched at bit 0: WORD_W by default, WORD_W-1 if a slip is pending, WORD_W+1 if a stretch is pending. If both are pending they cancel: len=WORD_W and both are cleared.
  - fco_out=1 iff bit_cnt < FCO_HIGH, so the FCO rising edge coincides with bit 0.
  - bit_valid=1 on every RUN cycle.
  - Back-to-back frames have no gap.
- Fault-injection requests:
  - slip_req and stretch_req set sticky pending flags, consumed at the next bit 0.
  - A request arriving on a bit-0 cycle applies to the following frame.
- Data path:
  - Outputs are registered. dout on bit_cnt=k is word bit WORD_W-1-k.
  - Slip frame: the LSB is dropped.
  - Stretch frame: the extra bit WORD_W drives 0 on every lane.
- Holding buffer (one entry):
  - s_ready = !hold_full || load_now, where load_now = RUN & bit_cnt==len-1 (or the IDLE->RUN cycle).
  - At bit 0 the shift register loads from the holding buffer, or from test_pattern on all lanes if test_pattern_en.
  - Input words are still consumed in test-pattern mode.
  - A word accepted on the same cycle as a load is held for the next frame, never skipped. Order is preserved with no loss and no duplication.
- Underrun:
  - At bit 0 with an empty buffer and test_pattern_en=0: send IDLE_WORD on all lanes, pulse underrun_pulse for 1 cycle, and increment underrun_count, saturating at all-ones.
  - Test-pattern mode never underruns.
- frame_start and underrun_pulse align with the bit-0 outputs.

Test Plan:
- Reset; enable=1; stream words lane0=16'hA5C3, lane1=16'h0FF0 continuously -> fco_out high 8 / low 8 cycles, period 16; dout0 serializes 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. Receiver monitor with lock_n_cfg=4 asserts aligned after 4 good frames; err_count=0.
- Single-cycle slip_req mid-frame -> next frame is 15 cycles with the LSB missing; the following frame is 16 cycles. Monitor pulses align_err_pulse once and err_count=1.
- slip_req and stretch_req asserted in the same cycle -> next frame is 16 cycles; no monitor error.
- s_valid=0 for 3 frames -> 3 IDLE_WORD frames, underrun_count=3; FCO period stays 16 throughout.
- enable deasserted at bit 5 -> the frame completes through bit 15, then bit_valid=0 and fco_out=0. Re-enable -> bit 0 of the new frame occurs on that cycle.
- rst_n pulsed low at bit 9 -> all outputs 0 immediately and underrun_count=0. After release with enable=1, a fresh frame starts.
